// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the fetch queue entry type
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory and decode handshake bundle of the fetch stage
interface instr_fetch_unit_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// rtl/instr_fetch_unit_fifo.sv - circular queue of fetched {pc, instr} entries with flush
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  slots [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC ownership, sequential word fetch issue and epoch-tagged response capture
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      redirect_valid,
    input  logic [cpu_pkg::XLEN-1:0]  redirect_pc,
    instr_fetch_unit_if.master        bus
);
    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tag_pc;
    logic            inflight;
    logic            epoch;
    logic            tag_epoch;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            full;
    logic            empty;
    logic            pop;
    logic            issue;
    logic            push;
    fetch_entry_t    head;
    fetch_entry_t    resp_entry;

    // Occupancy counts the outstanding request so the queue can never overflow;
    // a same-cycle pop frees a slot, giving one instruction per cycle.
    assign pop       = bus.dec_valid && bus.dec_ready;
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue     = !rst && en && !redirect_valid && (occupancy < (CW+1)'(DEPTH));

    // A response whose tag predates the last redirect is stale and dropped.
    assign push       = inflight && (tag_epoch == epoch) && !redirect_valid;
    assign resp_entry = fetch_entry_t'{pc: tag_pc, instr: bus.imem_rdata};

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.dec_valid = !empty;
    assign bus.dec_instr = head.instr;
    assign bus.dec_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            inflight  <= 1'b0;
            epoch     <= 1'b0;
            tag_pc    <= '0;
            tag_epoch <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= word_align(redirect_pc);
            epoch    <= ~epoch;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc        <= pc + XLEN'(INSTR_BYTES);
                tag_pc    <= pc;
                tag_epoch <= epoch;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (resp_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized and directed bench for instr_fetch_unit against a queue model
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    ent_t        q[$];
    logic [31:0] m_pc = 32'h0000_3000;
    bit          m_pend = 1'b0;
    logic [31:0] m_ppc = 32'h0;

    logic [98:0] exp_vec;
    logic [98:0] got_vec;
    logic        got_req;
    logic        got_dv;
    logic [31:0] got_addr;
    logic [31:0] got_pc;
    logic [31:0] got_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // One clock: drive inputs, predict outputs, sample at negedge, advance model at posedge.
    task automatic cyc(input bit e, input bit rv, input logic [31:0] rpc, input bit rdy, input bit r);
        bit pop;
        bit iss;
        bit dv;
        int occ;
        ent_t hd;
        en = e;
        redirect_valid = rv;
        redirect_pc = rpc;
        bus.dec_ready = rdy;
        rst = r;
        dv = (q.size() > 0);
        hd = '{pc: 32'h0, instr: 32'h0};
        if (dv) hd = q[0];
        pop = dv && rdy;
        occ = q.size() + int'(m_pend) - int'(pop);
        iss = !r && e && !rv && (occ < DEPTH);
        exp_vec = {iss, iss ? m_pc : 32'h0, dv, hd.pc, hd.instr};
        @(negedge clk);
        got_req = bus.imem_req;
        got_addr = bus.imem_addr;
        got_dv = bus.dec_valid;
        got_pc = bus.dec_pc;
        got_instr = bus.dec_instr;
        got_vec = {got_req, got_req ? got_addr : 32'h0, got_dv,
                   got_dv ? got_pc : 32'h0, got_dv ? got_instr : 32'h0};
        @(posedge clk);
        if (r) begin
            q.delete();
            m_pc = 32'h0000_3000;
            m_pend = 1'b0;
        end else if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
            m_pend = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_pend) q.push_back('{pc: m_ppc, instr: mem_word(m_ppc)});
            m_pend = iss;
            if (iss) begin
                m_ppc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        bus.imem_rdata = got_req ? mem_word(got_addr) : $urandom();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 32'h0, 1, 1);
            if (i > 0) begin
                n_checks++;
                if ({got_req, got_dv, got_pc, got_instr} !== 66'h0)
                    $display("FAIL reset[%0d] req=%b dv=%b pc=%h instr=%h, want all 0",
                             i, got_req, got_dv, got_pc, got_instr);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 32'h0, 1, 0);
            n_checks++;
            if (got_vec !== exp_vec) $display("FAIL seq[%0d] got %h want %h", i, got_vec, exp_vec);
            else n_pass++;
            if (i < 3) begin
                n_checks++;
                if (got_req !== 1'b1 || got_addr !== 32'h3000 + 32'(4 * i))
                    $display("FAIL seq_addr[%0d] req=%b addr=%h want %h", i, got_req, got_addr, 32'h3000 + 32'(4 * i));
                else n_pass++;
            end
            if (i >= 2 && i < 5) begin
                n_checks++;
                if (got_dv !== 1'b1 || got_pc !== 32'h3000 + 32'(4 * (i - 2)))
                    $display("FAIL seq_dec[%0d] dv=%b pc=%h want %h", i, got_dv, got_pc, 32'h3000 + 32'(4 * (i - 2)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        cyc(1, 0, 32'h0, 1, 1);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 32'h0, i >= 6, 0);
            n_checks++;
            if (got_vec !== exp_vec) $display("FAIL bp[%0d] got %h want %h", i, got_vec, exp_vec);
            else n_pass++;
            if (i >= 2 && i < 6) begin
                n_checks++;
                if (got_req !== 1'b0 || got_dv !== 1'b1 || got_pc !== 32'h3000)
                    $display("FAIL bp_full[%0d] req=%b dv=%b pc=%h want 0/1/3000", i, got_req, got_dv, got_pc);
                else n_pass++;
            end
            if (i == 6 || i == 7) begin
                n_checks++;
                if (got_dv !== 1'b1 || got_pc !== 32'h3000 + 32'(4 * (i - 6)))
                    $display("FAIL bp_drain[%0d] dv=%b pc=%h want %h", i, got_dv, got_pc, 32'h3000 + 32'(4 * (i - 6)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_redirect();
        cyc(1, 0, 32'h0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, i == 4, 32'h0000_4002, 1, 0);
            n_checks++;
            if (got_vec !== exp_vec) $display("FAIL redir[%0d] got %h want %h", i, got_vec, exp_vec);
            else n_pass++;
            if (i == 5) begin
                n_checks++;
                if (got_req !== 1'b1 || got_addr !== 32'h4000 || got_dv !== 1'b0)
                    $display("FAIL redir_n1 req=%b addr=%h dv=%b want 1/4000/0", got_req, got_addr, got_dv);
                else n_pass++;
            end
            if (i == 6) begin
                n_checks++;
                if (got_dv !== 1'b0) $display("FAIL redir_n2 dv=%b want 0", got_dv);
                else n_pass++;
            end
            if (i == 7) begin
                n_checks++;
                if (got_dv !== 1'b1 || got_pc !== 32'h4000 || got_instr !== mem_word(32'h4000))
                    $display("FAIL redir_n3 dv=%b pc=%h instr=%h want 1/4000/%h", got_dv, got_pc, got_instr, mem_word(32'h4000));
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        cyc(1, 1, 32'hFFFF_FFF9, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 32'h0, 1, 0);
            n_checks++;
            if (got_vec !== exp_vec) $display("FAIL wrap[%0d] got %h want %h", i, got_vec, exp_vec);
            else n_pass++;
            if (i < 3) begin
                want = 32'hFFFF_FFF8 + 32'(4 * i);
                n_checks++;
                if (got_req !== 1'b1 || got_addr !== want)
                    $display("FAIL wrap_addr[%0d] req=%b addr=%h want %h", i, got_req, got_addr, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable();
        cyc(1, 0, 32'h0, 1, 1);
        for (int i = 0; i < 12; i++) begin
            cyc(!(i >= 4 && i < 7), 0, 32'h0, 1, 0);
            n_checks++;
            if (got_vec !== exp_vec) $display("FAIL en[%0d] got %h want %h", i, got_vec, exp_vec);
            else n_pass++;
            if (i == 4 || i == 7) begin
                n_checks++;
                if (got_req !== (i == 7) || (i == 7 && got_addr !== 32'h3010))
                    $display("FAIL en_edge[%0d] req=%b addr=%h", i, got_req, got_addr);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 32'h0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 32'h0, i >= 5, i == 4);
            n_checks++;
            if (got_vec !== exp_vec) $display("FAIL rstmid[%0d] got %h want %h", i, got_vec, exp_vec);
            else n_pass++;
            if (i == 5) begin
                n_checks++;
                if (got_dv !== 1'b0 || got_req !== 1'b1 || got_addr !== 32'h3000)
                    $display("FAIL rstmid_restart dv=%b req=%b addr=%h want 0/1/3000", got_dv, got_req, got_addr);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        bit          e;
        bit          rv;
        bit          rdy;
        bit          r;
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            e   = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 19) == 0);
            r   = ($urandom_range(0, 49) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            cyc(e, rv, tgt, rdy, r);
            n_checks++;
            if (got_vec !== exp_vec) $display("FAIL rand[%0d] got %h want %h", i, got_vec, exp_vec);
            else n_pass++;
        end
    endtask

    initial begin
        bus.dec_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
